// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RV32IC pipeline.
// Boot hold, data-memory wait sequencing and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic             mem_mem_write,
    input  logic             mem_branch_taken,
    input  logic             dmem_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        DMEM_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

    state_t     state;
    logic [7:0] boot_cnt;

    logic mem_access;
    logic dmem_stall;
    logic branch;
    logic load_use;

    assign mem_access = mem_mem_read | mem_mem_write;

    // DMEM_WAIT freezes on ~dmem_ready alone; once ready it behaves exactly like RUN
    assign dmem_stall = ((state == RUN) & mem_access & ~dmem_ready) |
                        ((state == DMEM_WAIT) & ~dmem_ready);
    assign branch     = mem_branch_taken;
    assign load_use   = ex_mem_read & (ex_rd != 5'd0) &
                        ((id_uses_rs1 & (ex_rd == id_rs1)) |
                         (id_uses_rs2 & (ex_rd == id_rs2)));

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == rs))
            return 2'b10;
        else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        fwd_a        = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        fwd_b        = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            fwd_a        = 2'b00;
            fwd_b        = 2'b00;
        end else if (state == BOOT) begin
            pc_en        = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (dmem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (branch) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            boot_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                BOOT: begin
                    boot_cnt <= boot_cnt + 8'd1;
                    if (boot_cnt == BOOT_LAST)
                        state <= RUN;
                end
                RUN: begin
                    if (dmem_stall)
                        state <= DMEM_WAIT;
                end
                DMEM_WAIT: begin
                    if (dmem_ready)
                        state <= RUN;
                end
                default: state <= BOOT;
            endcase

            if ((state != BOOT) && !pc_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if ((state != BOOT) && !dmem_stall && branch && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a per-cycle rule model plus literal checks.
// A second instance with 2-bit counters exercises saturation.
module tb_pipeline_hazard_ctrl;

    localparam int BOOT_CYCLES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0;
    logic [4:0] mem_rd = '0, wb_rd = '0;
    logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic mem_reg_write = 1'b0, mem_mem_read = 1'b0, mem_mem_write = 1'b0;
    logic mem_branch_taken = 1'b0, dmem_ready = 1'b1, wb_reg_write = 1'b0;
    logic imem_ready = 1'b1;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
    logic s_if_id_flush, s_id_ex_flush, s_ex_mem_flush;
    logic [1:0] s_fwd_a, s_fwd_b;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_branch_taken(mem_branch_taken),
        .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .imem_ready(imem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_branch_taken(mem_branch_taken),
        .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .imem_ready(imem_ready),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
        .mem_wb_en(s_mem_wb_en), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .ex_mem_flush(s_ex_mem_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: phase 0 = holding after reset, 1 = running, 2 = waiting on data memory
    int m_phase = 0, m_boot = 0, m_stall = 0, m_flush = 0;
    int n_phase, n_boot, n_stall, n_flush;

    function automatic int fwd_model(input logic [4:0] rs);
        if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 1;
        return 0;
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    always @(negedge clk) begin
        logic [4:0] e_en;
        logic [2:0] e_fl;
        int e_fa, e_fb;
        bit frozen, lu;
        e_fa = fwd_model(ex_rs1);
        e_fb = fwd_model(ex_rs2);
        n_phase = m_phase; n_boot = m_boot; n_stall = m_stall; n_flush = m_flush;
        frozen = !dmem_ready && (m_phase == 2 || (m_phase == 1 && (mem_mem_read || mem_mem_write)));
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
        if (rst) begin
            e_en = 5'b00000; e_fl = 3'b111; e_fa = 0; e_fb = 0;
        end else if (m_phase == 0) begin
            e_en = 5'b01111; e_fl = 3'b111;
            n_boot = m_boot + 1;
            if (n_boot == BOOT_CYCLES) n_phase = 1;
        end else begin
            if (frozen)                begin e_en = 5'b00000; e_fl = 3'b000; end
            else if (mem_branch_taken) begin e_en = 5'b11111; e_fl = 3'b111; n_flush++; end
            else if (lu)               begin e_en = 5'b00111; e_fl = 3'b010; end
            else if (!imem_ready)      begin e_en = 5'b01111; e_fl = 3'b100; end
            else                       begin e_en = 5'b11111; e_fl = 3'b000; end
            if (!e_en[4]) n_stall++;
            n_phase = frozen ? 2 : 1;
        end
        chk("enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 32'(e_en));
        chk("flushes", {if_id_flush, id_ex_flush, ex_mem_flush}, 32'(e_fl));
        chk("fwd_a", 32'(fwd_a), e_fa);
        chk("fwd_b", 32'(fwd_b), e_fb);
        chk("stall_cnt", 32'(stall_cnt), sat(m_stall, 65535));
        chk("flush_cnt", 32'(flush_cnt), sat(m_flush, 65535));
        chk("sat_stall_cnt", 32'(s_stall_cnt), sat(m_stall, 3));
        chk("sat_flush_cnt", 32'(s_flush_cnt), sat(m_flush, 3));
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_boot = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_phase = n_phase; m_boot = n_boot; m_stall = n_stall; m_flush = n_flush;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_rd = 0;
        mem_reg_write = 0; wb_reg_write = 0; mem_mem_read = 0; mem_mem_write = 0;
        mem_branch_taken = 0; dmem_ready = 1; imem_ready = 1;
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; mem_rd = 0; wb_rd = 0;
    endtask

    task automatic boot_seq();
        rst = 1;
        step(); step();
        #1;
        chk("rst_pc_en", 32'(pc_en), 0);
        chk("rst_if_id_flush", 32'(if_id_flush), 1);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        rst = 0;
        repeat (BOOT_CYCLES - 1) step();
        #1;
        chk("boot_last_pc_en", 32'(pc_en), 0);
        step();
        #1;
        chk("run_pc_en", 32'(pc_en), 1);
        chk("run_flush", 32'(ex_mem_flush), 0);
        chk("boot_stall_cnt", 32'(stall_cnt), 0);
    endtask

    initial begin
        idle();
        boot_seq();

        // load-use: lw x5 in EX, ID reads x5
        ex_mem_read = 1; ex_rd = 5; id_uses_rs1 = 1; id_rs1 = 5; #1;
        chk("lu_pc_en", 32'(pc_en), 0);
        chk("lu_if_id_en", 32'(if_id_en), 0);
        chk("lu_id_ex_flush", 32'(id_ex_flush), 1);
        step(); idle(); #1;
        chk("lu_after_pc_en", 32'(pc_en), 1);
        chk("lu_stall_cnt", 32'(stall_cnt), 1);

        // data memory wait: 3 cycles not ready
        mem_mem_read = 1; dmem_ready = 0;
        repeat (3) begin
            #1;
            chk("dmem_frozen", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 0);
            step();
        end
        dmem_ready = 1; #1;
        chk("dmem_release_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 32'h1f);
        chk("dmem_stall_cnt", 32'(stall_cnt), 4);
        step(); idle();

        // branch together with load-use and fetch wait
        mem_branch_taken = 1; ex_mem_read = 1; ex_rd = 3; id_uses_rs2 = 1; id_rs2 = 3;
        imem_ready = 0; #1;
        chk("br_pc_en", 32'(pc_en), 1);
        chk("br_flushes", {if_id_flush, id_ex_flush, ex_mem_flush}, 32'h7);
        step(); idle(); #1;
        chk("br_flush_cnt", 32'(flush_cnt), 1);
        chk("br_stall_cnt", 32'(stall_cnt), 4);

        // forwarding
        ex_rs1 = 7; mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1; #1;
        chk("fwd_mem_prio", 32'(fwd_a), 2);
        mem_rd = 0; wb_rd = 0; #1;
        chk("fwd_x0", 32'(fwd_a), 0);
        ex_rs2 = 9; wb_rd = 9; mem_rd = 3; #1;
        chk("fwd_b_wb", 32'(fwd_b), 1);
        mem_rd = 7; wb_rd = 7; mem_reg_write = 0; #1;
        chk("fwd_a_wb_only", 32'(fwd_a), 1);
        step(); idle();

        // reset in the middle of a data-memory wait
        mem_mem_write = 1; dmem_ready = 0;
        step(); step();
        rst = 1; #1;
        chk("midrst_stall_cnt", 32'(stall_cnt), 0);
        chk("midrst_flush_cnt", 32'(flush_cnt), 0);
        chk("midrst_pc_en", 32'(pc_en), 0);
        idle();
        boot_seq();

        // fetch wait of 6 cycles saturates the 2-bit counter
        imem_ready = 0;
        repeat (6) step();
        #1;
        chk("fetch_if_id_flush", 32'(if_id_flush), 1);
        chk("fetch_stall_cnt", 32'(stall_cnt), 6);
        chk("sat_stall_literal", 32'(s_stall_cnt), 3);
        idle();

        // mixed directed sweep over a small register range
        for (int i = 0; i < 80; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1)); mem_reg_write = 1'($urandom_range(0, 1));
            wb_reg_write = 1'($urandom_range(0, 1));
            mem_mem_read = ($urandom_range(0, 3) == 0); mem_mem_write = ($urandom_range(0, 5) == 0);
            mem_branch_taken = ($urandom_range(0, 4) == 0);
            dmem_ready = ($urandom_range(0, 2) != 0); imem_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage RV32IC pipeline (IF, ID, EX, MEM, WB).
- Produces per-stage pipeline-register enables and flushes, and EX-stage operand forwarding selects.
- Sequences a post-reset boot hold and variable-latency data-memory waits.
- Keeps saturating stall and flush performance counters.

Parameters:
- BOOT_CYCLES, 4: cycles the PC is held after reset release (1..255).
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
- ex_rs1, ex_rs2  in  5 each  source registers held in the EX pipeline register.
- ex_rd  in  5  destination register in EX.
- ex_mem_read  in  1  EX instruction is a load.
- mem_rd  in  5  destination register in MEM.
- mem_reg_write  in  1  MEM instruction writes the register file.
- mem_mem_read, mem_mem_write  in  1 each  MEM stage is accessing data memory.
- mem_branch_taken  in  1  branch/jump resolved taken in MEM.
- dmem_ready  in  1  data memory completes the access this cycle.
- wb_rd  in  5  destination register in WB.
- wb_reg_write  in  1  WB instruction writes the register file.
- imem_ready  in  1  instruction memory returns a valid fetch this cycle.
- pc_en  out  1  PC register load enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble: all control bits cleared. Flush takes priority over enable inside the register.
- fwd_a, fwd_b  out  2 each  EX operand source: 00 = register file, 01 = WB, 10 = MEM.
- stall_cnt  out  CNT_W  cycles with pc_en=0 outside BOOT.
- flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- FSM states: BOOT, RUN, DMEM_WAIT. State and counters are registered. All other outputs are combinational from state and inputs.
- Reset (rst high, asynchronous):
  - state=BOOT, boot counter=0, stall_cnt=0, flush_cnt=0.
  - Outputs forced: all enables 0, all flushes 1, fwd_a=fwd_b=00.
- BOOT:
  - pc_en=0; all other enables 1; all flushes 1.
  - Boot counter increments each cycle; after BOOT_CYCLES cycles go to RUN.
  - Counters do not count in BOOT.
- RUN, evaluated in this priority order:
  1. Dmem stall: (mem_mem_read|mem_mem_write) & ~dmem_ready.
     - All enables 0, no flushes.
     - Next state DMEM_WAIT.
  2. Branch: mem_branch_taken.
     - All enables 1; if_id_flush, id_ex_flush, ex_mem_flush = 1.
     - flush_cnt += 1.
  3. Load-use: ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
     - pc_en=0, if_id_en=0, id_ex_flush=1; id_ex_en, ex_mem_en, mem_wb_en = 1.
  4. Fetch wait: ~imem_ready.
     - pc_en=0, if_id_flush=1; all other enables 1.
  5. Otherwise all enables 1, no flushes.
- DMEM_WAIT:
  - While ~dmem_ready: everything frozen, as in case 1.
  - When dmem_ready=1: return to RUN and, in the same cycle, apply RUN cases 2-5 as if no stall was pending. Total latency equals the memory latency; no extra bubble.
- stall_cnt increments in every RUN or DMEM_WAIT cycle with pc_en=0.
- Both counters saturate at 2^CNT_W-1; no wrap.
- Forwarding, independent of state:
  - fwd_a=10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1.
  - Else fwd_a=01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1.
  - Else fwd_a=00.
  - fwd_b uses the same rules with ex_rs2.
  - MEM has priority over WB. x0 never forwards.
- Simultaneous events:
  - Branch with load-use: branch wins; the flush discards the ID instruction, so no stall cycle.
  - Branch with ~imem_ready: branch wins. pc_en=1 loads the target; the wrong-path fetch is flushed.
- Reset asserted mid-DMEM_WAIT or mid-BOOT: immediately to BOOT with counters cleared.

Test Plan:
- Reset release, BOOT_CYCLES=4 -> pc_en=0 with flushes=1 for exactly 4 cycles, then pc_en=1 with flushes=0; stall_cnt stays 0.
- lw x5 in EX (ex_mem_read=1, ex_rd=5), ID add reads rs1=5 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; next cycle normal; stall_cnt=1.
- mem_mem_read=1, dmem_ready low for 3 cycles then high -> all enables 0 for 3 cycles, DMEM_WAIT entered and exited, enables 1 on cycle 4; stall_cnt=3.
- mem_branch_taken=1 together with a load-use hazard -> three flushes=1, pc_en=1, no stall; flush_cnt=1.
- ex_rs1=7 with mem_rd=7 and wb_rd=7 (both writing) -> fwd_a=10. Same with mem_rd=0 and wb_rd=0 -> fwd_a=00. ex_rs2=9, wb_rd=9 only -> fwd_b=01.
- CNT_W=2, hold imem_ready=0 for 6 cycles -> stall_cnt saturates at 3. rst pulsed mid-DMEM_WAIT -> counters 0, state BOOT.
